// File: rtl/qbu_tx_mux.sv
// Transmit-side merge of the Qbu MAC: arbitrates Verify, Respond, express and
// preemptable-fragment AXIS sources onto one stream toward the SMD/CRC framer.
module qbu_tx_mux #(
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned IFG_CYCLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,

    input  logic [DWIDTH-1:0]     i_Emac_tx_axis_data,
    input  logic [15:0]           i_Emac_tx_axis_user,
    input  logic [DWIDTH/8-1:0]   i_Emac_tx_axis_keep,
    input  logic                  i_Emac_tx_axis_last,
    input  logic                  i_Emac_tx_axis_valid,
    output logic                  o_Emac_tx_axis_ready,

    input  logic [DWIDTH-1:0]     i_Pmac_tx_axis_data,
    input  logic [15:0]           i_Pmac_tx_axis_user,
    input  logic [DWIDTH/8-1:0]   i_Pmac_tx_axis_keep,
    input  logic                  i_Pmac_tx_axis_last,
    input  logic                  i_Pmac_tx_axis_valid,
    output logic                  o_Pmac_tx_axis_ready,

    input  logic [DWIDTH-1:0]     i_R_tx_axis_data,
    input  logic [15:0]           i_R_tx_axis_user,
    input  logic [DWIDTH/8-1:0]   i_R_tx_axis_keep,
    input  logic                  i_R_tx_axis_last,
    input  logic                  i_R_tx_axis_valid,
    output logic                  o_R_tx_axis_ready,

    input  logic [DWIDTH-1:0]     i_V_tx_axis_data,
    input  logic [15:0]           i_V_tx_axis_user,
    input  logic [DWIDTH/8-1:0]   i_V_tx_axis_keep,
    input  logic                  i_V_tx_axis_last,
    input  logic                  i_V_tx_axis_valid,
    output logic                  o_V_tx_axis_ready,

    output logic [DWIDTH-1:0]     o_Sgram_tx_axis_data,
    output logic [15:0]           o_Sgram_tx_axis_user,
    output logic [DWIDTH/8-1:0]   o_Sgram_tx_axis_keep,
    output logic                  o_Sgram_tx_axis_last,
    output logic                  o_Sgram_tx_axis_valid,
    input  logic                  i_Sgram_tx_axis_ready
);

    localparam int unsigned KW = DWIDTH / 8;
    localparam int unsigned CW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    localparam logic [7:0] SMD_E = 8'hD5;
    localparam logic [7:0] SMD_R = 8'h19;
    localparam logic [7:0] SMD_V = 8'h07;

    typedef enum logic [2:0] {
        IDLE,
        GNT_V,
        GNT_R,
        GNT_E,
        GNT_P,
        GAP
    } state_t;

    state_t            state;
    logic [CW-1:0]     gap_cnt;

    logic [DWIDTH-1:0] sel_data;
    logic [KW-1:0]     sel_keep;
    logic [15:0]       sel_user;
    logic              sel_last;
    logic              sel_valid;
    logic              gnt_ready;
    logic              load;

    // Only the preemptable source carries framing info in its user word.
    logic              unused_user;
    assign unused_user = ^{i_Emac_tx_axis_user, i_R_tx_axis_user, i_V_tx_axis_user,
                           i_Pmac_tx_axis_user[15], i_Pmac_tx_axis_user[2:0]};

    assign gnt_ready = !o_Sgram_tx_axis_valid || i_Sgram_tx_axis_ready;

    assign o_V_tx_axis_ready    = (state == GNT_V) && gnt_ready;
    assign o_R_tx_axis_ready    = (state == GNT_R) && gnt_ready;
    assign o_Emac_tx_axis_ready = (state == GNT_E) && gnt_ready;
    assign o_Pmac_tx_axis_ready = (state == GNT_P) && gnt_ready;

    // Granted-source mux and user-word construction.
    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_user  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        case (state)
            GNT_V: begin
                sel_data  = i_V_tx_axis_data;
                sel_keep  = i_V_tx_axis_keep;
                sel_last  = i_V_tx_axis_last;
                sel_valid = i_V_tx_axis_valid;
                sel_user  = {1'b1, SMD_V, 2'b00, 2'b01, 1'b0, 2'b00};
            end
            GNT_R: begin
                sel_data  = i_R_tx_axis_data;
                sel_keep  = i_R_tx_axis_keep;
                sel_last  = i_R_tx_axis_last;
                sel_valid = i_R_tx_axis_valid;
                sel_user  = {1'b1, SMD_R, 2'b00, 2'b01, 1'b0, 2'b00};
            end
            GNT_E: begin
                sel_data  = i_Emac_tx_axis_data;
                sel_keep  = i_Emac_tx_axis_keep;
                sel_last  = i_Emac_tx_axis_last;
                sel_valid = i_Emac_tx_axis_valid;
                sel_user  = {1'b1, SMD_E, 2'b00, 2'b01, 1'b0, 2'b00};
            end
            GNT_P: begin
                sel_data  = i_Pmac_tx_axis_data;
                sel_keep  = i_Pmac_tx_axis_keep;
                sel_last  = i_Pmac_tx_axis_last;
                sel_valid = i_Pmac_tx_axis_valid;
                sel_user  = {1'b1, i_Pmac_tx_axis_user[14:7], i_Pmac_tx_axis_user[6:5],
                             i_Pmac_tx_axis_user[4:3], 1'b1, 2'b00};
            end
            default: ;
        endcase
    end

    assign load = sel_valid && gnt_ready;

    // Arbitration FSM and output register slice.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                 <= IDLE;
            gap_cnt               <= '0;
            o_Sgram_tx_axis_data  <= '0;
            o_Sgram_tx_axis_user  <= '0;
            o_Sgram_tx_axis_keep  <= '0;
            o_Sgram_tx_axis_last  <= 1'b0;
            o_Sgram_tx_axis_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_V_tx_axis_valid)         state <= GNT_V;
                    else if (i_R_tx_axis_valid)    state <= GNT_R;
                    else if (i_Emac_tx_axis_valid) state <= GNT_E;
                    else if (i_Pmac_tx_axis_valid) state <= GNT_P;
                end
                GNT_V, GNT_R, GNT_E, GNT_P: begin
                    if (load && sel_last) begin
                        gap_cnt <= '0;
                        state   <= (IFG_CYCLES > 0) ? GAP : IDLE;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == CW'(IFG_CYCLES - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Stalled beats hold; a drained register reads back as all zero.
            if (load) begin
                o_Sgram_tx_axis_data  <= sel_data;
                o_Sgram_tx_axis_user  <= sel_user;
                o_Sgram_tx_axis_keep  <= sel_keep;
                o_Sgram_tx_axis_last  <= sel_last;
                o_Sgram_tx_axis_valid <= 1'b1;
            end else if (i_Sgram_tx_axis_ready) begin
                o_Sgram_tx_axis_data  <= '0;
                o_Sgram_tx_axis_user  <= '0;
                o_Sgram_tx_axis_keep  <= '0;
                o_Sgram_tx_axis_last  <= 1'b0;
                o_Sgram_tx_axis_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qbu_tx_mux.sv
// Randomized bench for qbu_tx_mux: per-source frame queues feed a frame-level
// priority scoreboard, plus latency, stall, one-hot ready and idle-gap checks.
module tb_qbu_tx_mux;

    localparam int unsigned DW  = 8;
    localparam int unsigned KW  = DW / 8;
    localparam int unsigned IFG = 4;
    localparam int V = 0;
    localparam int R = 1;
    localparam int E = 2;
    localparam int P = 3;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [15:0]   user;
    } beat_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_data [4];
    logic [KW-1:0] s_keep [4];
    logic [15:0]   s_user [4];
    logic [3:0]    s_last;
    logic [3:0]    s_valid;
    logic [3:0]    s_ready;
    logic          rdy_v, rdy_r, rdy_e, rdy_p;
    logic [DW-1:0] o_data;
    logic [15:0]   o_user;
    logic [KW-1:0] o_keep;
    logic          o_last;
    logic          o_valid;
    logic          sready;

    assign s_ready = {rdy_p, rdy_e, rdy_r, rdy_v};

    qbu_tx_mux #(.DWIDTH(DW), .IFG_CYCLES(IFG)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_Emac_tx_axis_data(s_data[E]),
        .i_Emac_tx_axis_user(s_user[E]),
        .i_Emac_tx_axis_keep(s_keep[E]),
        .i_Emac_tx_axis_last(s_last[E]),
        .i_Emac_tx_axis_valid(s_valid[E]),
        .o_Emac_tx_axis_ready(rdy_e),
        .i_Pmac_tx_axis_data(s_data[P]),
        .i_Pmac_tx_axis_user(s_user[P]),
        .i_Pmac_tx_axis_keep(s_keep[P]),
        .i_Pmac_tx_axis_last(s_last[P]),
        .i_Pmac_tx_axis_valid(s_valid[P]),
        .o_Pmac_tx_axis_ready(rdy_p),
        .i_R_tx_axis_data(s_data[R]),
        .i_R_tx_axis_user(s_user[R]),
        .i_R_tx_axis_keep(s_keep[R]),
        .i_R_tx_axis_last(s_last[R]),
        .i_R_tx_axis_valid(s_valid[R]),
        .o_R_tx_axis_ready(rdy_r),
        .i_V_tx_axis_data(s_data[V]),
        .i_V_tx_axis_user(s_user[V]),
        .i_V_tx_axis_keep(s_keep[V]),
        .i_V_tx_axis_last(s_last[V]),
        .i_V_tx_axis_valid(s_valid[V]),
        .o_V_tx_axis_ready(rdy_v),
        .o_Sgram_tx_axis_data(o_data),
        .o_Sgram_tx_axis_user(o_user),
        .o_Sgram_tx_axis_keep(o_keep),
        .o_Sgram_tx_axis_last(o_last),
        .o_Sgram_tx_axis_valid(o_valid),
        .i_Sgram_tx_axis_ready(sready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_total = 0;
    int    n_bad   = 0;
    int    cyc     = 0;
    beat_t drv_q [4][$];
    beat_t exp_q [4][$];
    logic [3:0] started = '0;
    logic [3:0] acc     = '0;
    bit    in_rst  = 1'b1;
    int    bp_mode = 0;
    int    bp_pct  = 0;
    int    gap_pct = 0;
    bit    p_seen  = 1'b0;

    // monitor state
    bit    in_frame    = 1'b0;
    int    cur         = -1;
    bit    prev_in_vld = 1'b0;
    logic [DW-1:0] prev_in_data = '0;
    bit    prev_stall  = 1'b0;
    logic [DW+KW+1:0] prev_out = '0;
    logic [15:0] prev_user = '0;
    bit    gap_armed = 1'b0;
    bit    gap_pend  = 1'b0;
    bit    gap_exact = 1'b0;
    int    gap_start = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_user(input int s, input logic [15:0] u);
        case (s)
            V:       return {1'b1, 8'h07, 2'b00, 2'b01, 1'b0, 2'b00};
            R:       return {1'b1, 8'h19, 2'b00, 2'b01, 1'b0, 2'b00};
            E:       return {1'b1, 8'hD5, 2'b00, 2'b01, 1'b0, 2'b00};
            default: return {1'b1, u[14:7], u[6:5], u[4:3], 1'b1, 2'b00};
        endcase
    endfunction

    function automatic bit busy();
        for (int s = 0; s < 4; s++)
            if (drv_q[s].size() != 0 || exp_q[s].size() != 0) return 1'b1;
        return o_valid;
    endfunction

    task automatic add_frame(input int s, input int len, input bit seq, input logic [15:0] user);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = seq ? DW'(i) : DW'($urandom);
            b.keep = KW'($urandom);
            b.last = (i == len - 1);
            b.user = user;
            drv_q[s].push_back(b);
            exp_q[s].push_back(b);
        end
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (busy() && t < budget) begin
            @(negedge clk); #1;
            t++;
        end
        check("drain_timeout", 32'(busy()), 32'd0);
        repeat (IFG + 3) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        in_rst  = 1'b1;
        rst     = 1'b1;
        acc     = '0;
        s_valid = '0;
        for (int s = 0; s < 4; s++) begin
            drv_q[s].delete();
            exp_q[s].delete();
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_fields", 32'({o_data, o_keep, o_last}), 32'd0);
        check("rst_user", 32'(o_user), 32'd0);
        in_rst = 1'b0;
    endtask

    // Source drivers and framer ready, updated just after each rising edge.
    initial begin
        beat_t b;
        sready  = 1'b1;
        s_valid = '0;
        s_last  = '0;
        for (int s = 0; s < 4; s++) begin
            s_data[s] = '0;
            s_keep[s] = '0;
            s_user[s] = '0;
        end
        forever begin
            @(posedge clk); #1;
            if (in_rst) begin
                s_valid = '0;
                started = '0;
                sready  = 1'b1;
            end else begin
                for (int s = 0; s < 4; s++) begin
                    if (acc[s] && drv_q[s].size() != 0) begin
                        b = drv_q[s].pop_front();
                        started[s] = !b.last;
                    end
                end
                for (int s = 0; s < 4; s++) begin
                    if (drv_q[s].size() != 0) begin
                        b = drv_q[s][0];
                        s_data[s]  = b.data;
                        s_keep[s]  = b.keep;
                        s_user[s]  = b.user;
                        s_last[s]  = b.last;
                        s_valid[s] = started[s] ? (int'($urandom_range(0, 99)) >= gap_pct) : 1'b1;
                    end else begin
                        s_valid[s] = 1'b0;
                        s_last[s]  = 1'b0;
                        s_data[s]  = '0;
                    end
                end
                case (bp_mode)
                    0:       sready = 1'b1;
                    1:       sready = ~sready;
                    default: sready = int'($urandom_range(0, 99)) >= bp_pct;
                endcase
            end
        end
    end

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        beat_t b;
        cyc++;
        if (in_rst) begin
            in_frame    = 1'b0;
            prev_in_vld = 1'b0;
            prev_stall  = 1'b0;
            gap_armed   = 1'b0;
            gap_pend    = 1'b0;
            acc         = '0;
        end else begin
            if (prev_in_vld) begin
                check("lat_valid", 32'(o_valid), 32'd1);
                check("lat_data", 32'(o_data), 32'(prev_in_data));
            end
            if (prev_stall) begin
                check("stall_hold", 32'({o_data, o_keep, o_last, o_valid}), 32'(prev_out));
                check("stall_user", 32'(o_user), 32'(prev_user));
            end
            if (o_valid && sready) begin
                if (!in_frame) begin
                    cur = -1;
                    for (int s = 3; s >= 0; s--)
                        if (exp_q[s].size() != 0) cur = s;
                end
                if (cur < 0 || exp_q[cur].size() == 0) begin
                    check("spurious_beat", 32'd1, 32'd0);
                end else begin
                    b = exp_q[cur].pop_front();
                    check("out_data", 32'(o_data), 32'(b.data));
                    check("out_keep", 32'(o_keep), 32'(b.keep));
                    check("out_last", 32'(o_last), 32'(b.last));
                    check("out_user", 32'(o_user), 32'(exp_user(cur, b.user)));
                    in_frame = !b.last;
                    if (cur == P) p_seen = 1'b1;
                end
            end
            check("ready_onehot", 32'($countones(s_ready) <= 1), 32'd1);
            if (gap_pend) begin
                gap_exact = (|s_valid) && (bp_mode == 0);
                gap_pend  = 1'b0;
            end
            if (gap_armed && (|s_ready)) begin
                if (gap_exact) check("ifg_exact", 32'(cyc - gap_start), 32'(IFG + 2));
                else           check("ifg_min", 32'((cyc - gap_start) >= int'(IFG + 2)), 32'd1);
                gap_armed = 1'b0;
            end
            acc = s_valid & s_ready;
            prev_in_vld = |acc;
            for (int s = 0; s < 4; s++) begin
                if (acc[s]) begin
                    prev_in_data = s_data[s];
                    if (s_last[s]) begin
                        gap_armed = 1'b1;
                        gap_pend  = 1'b1;
                        gap_start = cyc;
                    end
                end
            end
            prev_stall = o_valid && !sready;
            prev_out   = {o_data, o_keep, o_last, o_valid};
            prev_user  = o_user;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check("init_valid", 32'(o_valid), 32'd0);
        check("init_ready", 32'(s_ready), 32'd0);
        check("init_user", 32'(o_user), 32'd0);
        in_rst = 1'b0;

        // Long express frame with counting data
        bp_mode = 0; gap_pct = 0;
        add_frame(E, 64, 1'b1, 16'($urandom));
        wait_drain(500);

        // All four sources requesting at once
        add_frame(V, 4, 1'b0, 16'($urandom));
        add_frame(R, 4, 1'b0, 16'($urandom));
        add_frame(E, 4, 1'b0, 16'($urandom));
        add_frame(P, 4, 1'b0, 16'($urandom));
        wait_drain(500);

        // Alternating framer backpressure
        bp_mode = 1;
        add_frame(E, 10, 1'b0, 16'($urandom));
        wait_drain(500);
        bp_mode = 0;

        // Preemptable fragment info passthrough; bits 15 and 2:0 must be ignored
        add_frame(P, 8, 1'b0, 16'hB0D5);
        wait_drain(500);

        // Express frame arriving mid-fragment goes ahead of the next fragment
        p_seen = 1'b0;
        add_frame(P, 8, 1'b0, 16'h2A48);
        add_frame(P, 8, 1'b0, 16'h2A70);
        t = 0;
        while (!p_seen && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        check("pmac_started", 32'(p_seen), 32'd1);
        add_frame(E, 5, 1'b0, 16'($urandom));
        wait_drain(500);

        // Randomized mixes with backpressure and mid-frame valid gaps
        for (int it = 0; it < 30; it++) begin
            bp_mode = 2;
            bp_pct  = int'($urandom_range(0, 60));
            gap_pct = int'($urandom_range(0, 50));
            for (int s = 0; s < 4; s++) begin
                int nf;
                nf = int'($urandom_range(0, 2));
                for (int f = 0; f < nf; f++)
                    add_frame(s, int'($urandom_range(1, 6)), 1'b0, 16'($urandom));
            end
            wait_drain(3000);
        end

        // Reset in the middle of traffic, then recovery
        bp_mode = 0; gap_pct = 0;
        add_frame(R, 6, 1'b0, 16'($urandom));
        add_frame(E, 6, 1'b0, 16'($urandom));
        add_frame(P, 6, 1'b0, 16'($urandom));
        repeat (9) @(negedge clk);
        do_reset();
        add_frame(E, 3, 1'b0, 16'($urandom));
        add_frame(P, 3, 1'b0, 16'($urandom));
        wait_drain(500);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/qbu_tx_mux.md
Name: qbu_tx_mux

Overview:
- Transmit-side merge point of the Qbu MAC: the counterpart of the RX splitter that routes frames to the Emac, Pmac, R and V queues by SMD.
- Arbitrates four AXIS sources (express MAC, preemptable-fragment MAC, Respond, Verify) onto one stream toward the SMD/CRC framer.
- Holds each grant for a whole frame or fragment, and inserts a programmable idle gap between grants.
- Builds the output user word (SMD, fragment count, CRC mode, qbu flag) so the framer knows which SMD and CRC to emit.

Parameters:
- DWIDTH, 8, data width in bits; keep width is DWIDTH/8.
- IFG_CYCLES, 4, idle cycles between the last-beat acceptance and the next arbitration (0 allowed).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_X_tx_axis_data  in  DWIDTH  source data, X in {Emac,Pmac,R,V}
- i_X_tx_axis_user  in  16  source info; only Pmac is used: [14:7] SMD, [6:5] frag_cnt, [4:3] crc mode
- i_X_tx_axis_keep  in  DWIDTH/8  byte mask
- i_X_tx_axis_last  in  1  end of frame/fragment
- i_X_tx_axis_valid  in  1  beat valid
- o_X_tx_axis_ready  out  1  beat accepted
- o_Sgram_tx_axis_data  out  DWIDTH  merged data
- o_Sgram_tx_axis_user  out  16  {info_vld, smd[7:0], frag_cnt[1:0], crc_mode[1:0], qbu_frm, 2'b00}
- o_Sgram_tx_axis_keep  out  DWIDTH/8  byte mask
- o_Sgram_tx_axis_last  out  1  end of frame/fragment
- o_Sgram_tx_axis_valid  out  1  beat valid
- i_Sgram_tx_axis_ready  in  1  framer ready

Behaviour:
- FSM states: IDLE, GNT_V, GNT_R, GNT_E, GNT_P, GAP.
- Reset: state IDLE, gap counter 0; all o_* outputs 0, including every ready.
- IDLE: sample the input valids and pick by fixed priority V > R > Emac > Pmac. The grant state is entered the next cycle. If no valid is present, stay in IDLE.
- Express-over-preemptable priority applies only at fragment boundaries. The Pmac source delivers already-fragmented data, and each fragment ends with last.
- Output is one register slice. load = granted source valid && ready. Granted source ready = !o_valid || i_Sgram_tx_axis_ready; all other readies are 0.
- Input-to-output latency is 1 cycle. o_valid clears on an output handshake with no new load.
- Stall: while o_valid=1 and framer ready=0, all output fields hold stable.
- User word on load:
  - Emac: smd D5.
  - R: smd 19.
  - V: smd 07.
  - Emac/R/V common fields: frag 0, crc_mode 01, qbu_frm 0, info_vld 1.
  - Pmac: smd, frag and crc_mode copied from input user [14:7], [6:5], [4:3]; qbu_frm 1; info_vld 1.
- When the register is not loaded with a new beat, all output fields are 0.
- Grant exit: an accepted input beat with last=1 moves to GAP when IFG_CYCLES>0, otherwise to IDLE. The counter loads 0.
- GAP: counter increments each cycle; move to IDLE once the counter reaches IFG_CYCLES-1.
- Minimum timing: accepting last in cycle n allows the next grant's first ready no earlier than cycle n+IFG_CYCLES+2.
- Valid deasserting mid-frame: the grant is held, with no timeout.
- Other sources' valids are ignored while granted.
- Reset mid-frame: all state is discarded immediately and no partial-frame completion is generated.

Test Plan:
- Reset then idle: all outputs 0 → assert i_rst for 2 cycles during traffic; the cycle after, o_valid=0 and all readies 0.
- Single Emac frame: 64 beats, data 0x00..0x3F, ready=1 → output identical one cycle later; user=0xEA88 (info 1, smd D5, crc 01); last on beat 64.
- Simultaneous requests: V, R, Emac and Pmac valid in the same cycle, each 4 beats, IFG_CYCLES=4 → output order V, R, Emac, Pmac. Between each last acceptance and the next first ready there are exactly 5 idle cycles.
- Backpressure: framer ready toggles 1010… over a 10-beat Emac frame → no beat lost or duplicated, data stable while stalled, 10 outputs in order.
- Pmac fragment passthrough: input user[14:7]=0x61, frag_cnt=2, crc 10, 8 beats → output user = {1, 0x61, 2'b10, 2'b10, 1, 2'b00} = 0xB0D4.
- Express between fragments: Emac valid arrives mid Pmac fragment → Pmac fragment completes, then the Emac frame is granted before the next Pmac fragment.
